// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching fetch stage.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 16
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif

package fetch_pkg;

    localparam int DEF_ADDR_W  = `ADDRESS_SIZE;
    localparam int DEF_INSTR_W = `INSTRUCTION_SIZE;

    localparam logic [DEF_INSTR_W-1:0] NOP = '0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP,
        HALTED
    } fetch_state_t;

    // Queue entries are {pc, instruction}.
    function automatic int entry_w(input int addr_w, input int instr_w);
        return addr_w + instr_w;
    endfunction

endpackage

// File: rtl/prefetch_fetch_unit_if.sv
// Program-memory request/acknowledge bus between fetch and memory.
interface prefetch_fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) ();

    logic               mem_req;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instruction;
    logic               mem_ack;

    modport master (
        output mem_req,
        output pc,
        input  instruction,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  pc,
        output instruction,
        output mem_ack
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with push, pop, flush and occupancy count.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full queue still accepts a push when the head leaves this cycle.
    assign do_push  = push && (!full || do_pop);
    assign data_out = slots[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push && !flush)
            slots[wr_ptr] <= data_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Fetch stage: request FSM feeding a DEPTH-entry prefetch queue.
// Define FETCH_BYPASS_EN to forward an ack straight out when the queue is empty.
module prefetch_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       halt,
    input  logic                       jump,
    input  logic [ADDR_W-1:0]          jump_pc,
    input  logic                       stall,
    prefetch_fetch_unit_if.master      mem,
    output logic [INSTR_W-1:0]         instruction_out,
    output logic [ADDR_W-1:0]          out_pc,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = entry_w(ADDR_W, INSTR_W);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic               halted;
    logic               ack_take;
    logic               bypass;
    logic               head_valid;
    logic               push;
    logic               pop;
    logic               flush;
    logic               q_empty;
    logic [ENTRY_W-1:0] q_head;
    logic [CNT_W:0]     count_after;

    assign ack_take   = (state == WAIT) && mem.mem_ack && !jump && !halt;
    assign flush      = jump || halt;
    assign head_valid = !q_empty;

`ifdef FETCH_BYPASS_EN
    assign bypass = ack_take && q_empty;
`else
    assign bypass = 1'b0;
`endif

    assign pop  = head_valid && !stall && !flush;
    // A bypassed word that is consumed right away never enters the queue.
    assign push = ack_take && !(bypass && !stall);

    assign count_after = {1'b0, count}
                       + {{CNT_W{1'b0}}, push}
                       - {{CNT_W{1'b0}}, pop};

    assign mem.mem_req = (state == WAIT) || (state == DROP);
    assign mem.pc      = fetch_pc;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .data_in  ({fetch_pc, mem.instruction}),
        .data_out (q_head),
        .count    (count),
        .empty    (q_empty)
    );

    always_comb begin
        out_valid       = head_valid || bypass;
        out_pc          = '0;
        instruction_out = INSTR_W'(NOP);
        if (head_valid) begin
            {out_pc, instruction_out} = q_head;
        end else if (bypass) begin
            out_pc          = fetch_pc;
            instruction_out = mem.instruction;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
        end else begin
            if (halt)
                halted <= 1'b1;
            else if (jump && !halted)
                fetch_pc <= jump_pc;
            else if (ack_take)
                fetch_pc <= fetch_pc + 1'b1;

            unique case (state)
                IDLE: begin
                    if (halt)
                        state <= HALTED;
                    else if (jump)
                        state <= WAIT;
                    else if (!halted && count < CNT_W'(DEPTH))
                        state <= WAIT;
                end
                WAIT: begin
                    if (halt || jump) begin
                        if (!mem.mem_ack)
                            state <= DROP;
                        else
                            state <= halt ? HALTED : WAIT;
                    end else if (mem.mem_ack) begin
                        state <= (count_after < (CNT_W+1)'(DEPTH))
                                 ? WAIT : IDLE;
                    end
                end
                // Stale response still owed; a jump only retargets fetch_pc.
                DROP: begin
                    if (mem.mem_ack)
                        state <= (halt || halted) ? HALTED : WAIT;
                end
                HALTED: state <= HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Randomized bench for prefetch_fetch_unit with a transaction-level model.
module tb_prefetch_fetch_unit;

    localparam int AW    = 8;
    localparam int IW    = 32;
    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] ins;
    } ent_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          halt = 1'b0;
    logic          jump = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] jump_pc = '0;
    logic [IW-1:0] instruction_out;
    logic [AW-1:0] out_pc;
    logic          out_valid;
    logic [2:0]    count;

    prefetch_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) mem_bus ();

    prefetch_fetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .halt            (halt),
        .jump            (jump),
        .jump_pc         (jump_pc),
        .stall           (stall),
        .mem             (mem_bus),
        .instruction_out (instruction_out),
        .out_pc          (out_pc),
        .out_valid       (out_valid),
        .count           (count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: queue contents, next fetch address, and the outstanding
    // request (0 none, 1 live, 2 stale) plus the halted flag.
    ent_t          q[$];
    logic [AW-1:0] m_pc = '0;
    bit            m_halted = 1'b0;
    int            m_req = 0;
    int            wait_cnt = 0;

    bit            rand_ack = 1'b0;
    int            ack_pct = 100;
    int            ack_delay = 0;
    int            stall_pct = 0;
    bit            s_valid;
    logic [AW-1:0] s_pc;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        halt = 1'b0;
        jump = 1'b0;
        stall = 1'b0;
        mem_bus.mem_ack = 1'b0;
        #1;
        q.delete();
        m_pc = '0;
        m_halted = 1'b0;
        m_req = 0;
        wait_cnt = 0;
        check("rst_mem_req", mem_bus.mem_req, 0);
        check("rst_pc", mem_bus.pc, 0);
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_instr", instruction_out, 0);
        check("rst_out_pc", out_pc, 0);
        #3;
        reset = 1'b1;
    endtask

    task automatic cycle(input bit j, input logic [AW-1:0] jp, input bit h);
        bit            ack;
        bit            st;
        bit            take;
        bit            byp;
        bit            pop;
        int            c0;
        logic [IW-1:0] ins;
        ins = $urandom;
        st  = ($urandom_range(99) < stall_pct);
        ack = 1'b0;
        if (m_req != 0) begin
            if (rand_ack)
                ack = ($urandom_range(99) < ack_pct);
            else
                ack = (wait_cnt >= ack_delay);
        end
        wait_cnt = (m_req != 0 && !ack) ? wait_cnt + 1 : 0;
        halt = h;
        jump = j;
        jump_pc = jp;
        stall = st;
        mem_bus.mem_ack = ack;
        mem_bus.instruction = ins;

        c0   = q.size();
        take = (m_req == 1) && ack && !j && !h;
        byp  = (LAT == 0) && take && (c0 == 0);
        pop  = (c0 > 0) && !st && !j && !h;

        #1;
        check("mem_req", mem_bus.mem_req, m_req != 0);
        check("pc", mem_bus.pc, m_pc);
        check("count", count, c0);
        check("out_valid", out_valid, (c0 > 0) || byp);
        if (c0 > 0) begin
            check("instr", instruction_out, q[0].ins);
            check("out_pc", out_pc, q[0].pc);
        end else if (byp) begin
            check("byp_instr", instruction_out, ins);
            check("byp_out_pc", out_pc, m_pc);
        end else begin
            check("nop_instr", instruction_out, 0);
            check("nop_out_pc", out_pc, 0);
        end
        s_valid = out_valid;
        s_pc = out_pc;

        @(posedge clock);
        if (h) begin
            q.delete();
            m_halted = 1'b1;
            m_req = (m_req != 0 && !ack) ? 2 : 0;
        end else if (m_halted) begin
            if (ack)
                m_req = 0;
        end else if (j) begin
            q.delete();
            m_pc = jp;
            m_req = (m_req != 0 && !ack) ? 2 : 1;
        end else begin
            if (pop)
                void'(q.pop_front());
            if (m_req == 2) begin
                if (ack)
                    m_req = 1;
            end else if (m_req == 1) begin
                if (ack) begin
                    if (!(byp && !st))
                        q.push_back('{pc: m_pc, ins: ins});
                    m_pc = m_pc + 1'b1;
                    m_req = (q.size() < DEPTH) ? 1 : 0;
                end
            end else if (c0 < DEPTH) begin
                m_req = 1;
            end
        end
        #1;
        halt = 1'b0;
        jump = 1'b0;
        mem_bus.mem_ack = 1'b0;
    endtask

    initial begin
        int            got;
        int            halt_wait;
        logic [AW-1:0] seen [3];
        mem_bus.mem_ack = 1'b0;
        mem_bus.instruction = '0;
        @(posedge clock);
        #1;
        do_reset();

        // Zero-wait memory, no stall.
        cycle(0, '0, 0);
        check("start_req", mem_bus.mem_req, 1);
        check("start_pc", mem_bus.pc, 0);
        cycle(0, '0, 0);
        check("first_same_cycle", s_valid, LAT == 0);
        check("first_count", count, LAT);
        check("pc_after_ack", mem_bus.pc, 1);
        for (int n = 2; n <= 8; n++) begin
            cycle(0, '0, 0);
            check("seq_valid", s_valid, 1);
            check("seq_out_pc", s_pc, AW'(n - 1 - LAT));
            check("count_le1", count <= 3'd1, 1);
        end

        // Stall held: queue fills and requests stop.
        stall_pct = 100;
        for (int n = 0; n < 10; n++)
            cycle(0, '0, 0);
        check("full_count", count, 4);
        check("full_no_req", mem_bus.mem_req, 0);
        stall_pct = 0;
        cycle(0, '0, 0);
        check("drain1_count", count, 3);
        check("drain1_req", mem_bus.mem_req, 0);
        cycle(0, '0, 0);
        check("drain2_count", count, 2);
        check("drain2_req", mem_bus.mem_req, 1);

        // Jump together with an ack and a pop.
        for (int n = 0; n < 3; n++)
            cycle(0, '0, 0);
        cycle(1, 8'h20, 0);
        check("jmp_count", count, 0);
        check("jmp_valid", out_valid, 0);
        check("jmp_req", mem_bus.mem_req, 1);
        check("jmp_pc", mem_bus.pc, 8'h20);

        // Address wrap through a jump near the top.
        cycle(1, 8'hFE, 0);
        got = 0;
        for (int n = 0; n < 20 && got < 3; n++) begin
            cycle(0, '0, 0);
            if (s_valid) begin
                seen[got] = s_pc;
                got++;
            end
        end
        check("wrap_seen", got, 3);
        check("wrap_0", seen[0], 8'hFE);
        check("wrap_1", seen[1], 8'hFF);
        check("wrap_2", seen[2], 8'h00);

        // Slow memory, jump while a request is outstanding.
        do_reset();
        ack_delay = 3;
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        cycle(1, 8'h40, 0);
        check("drop_req", mem_bus.mem_req, 1);
        check("drop_pc", mem_bus.pc, 8'h40);
        got = 0;
        for (int n = 0; n < 30 && got == 0; n++) begin
            cycle(0, '0, 0);
            if (s_valid) begin
                got = 1;
                check("drop_first_pc", s_pc, 8'h40);
            end
        end
        check("drop_seen", got, 1);

        // Halt and jump together.
        ack_delay = 0;
        cycle(0, '0, 0);
        cycle(1, 8'h10, 1);
        for (int n = 0; n < 5; n++) begin
            cycle(0, '0, 0);
            check("halt_req", mem_bus.mem_req, 0);
            check("halt_valid", s_valid, 0);
            check("halt_count", count, 0);
        end

        // Asynchronous reset while a request waits.
        do_reset();
        ack_delay = 5;
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        check("midwait_req", mem_bus.mem_req, 1);
        do_reset();

        // Random traffic.
        rand_ack = 1'b1;
        halt_wait = 0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0) begin
                ack_pct = $urandom_range(20, 100);
                stall_pct = $urandom_range(0, 80);
            end
            cycle($urandom_range(99) < 4, AW'($urandom),
                  $urandom_range(999) < 3);
            if (m_halted && m_req == 0) begin
                halt_wait++;
                if (halt_wait > 6) begin
                    do_reset();
                    halt_wait = 0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
